// File: rtl/ahb_master_if.sv
// AHB-Lite initiator: turns local read/write commands into SINGLE or INCR bursts of
// 32-bit word transfers, with write data pipelined one beat behind the address, read
// data capture, wait-state handling and two-cycle ERROR termination.
module ahb_master_if #(
   parameter int unsigned LEN_W = 4
) (
   input  logic             Hclk,
   input  logic             Hresetn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [31:0]      cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [31:0]      wr_data,
   output logic             wr_req,
   input  logic             Hreadyout,
   input  logic [1:0]       Hresp,
   input  logic [31:0]      Hrdata,
   output logic [31:0]      Haddr,
   output logic             Hwrite,
   output logic [1:0]       Htrans,
   output logic [2:0]       Hsize,
   output logic [2:0]       Hburst,
   output logic [31:0]      Hwdata,
   output logic [31:0]      rd_data,
   output logic             rd_valid,
   output logic             done,
   output logic             err
);

   localparam logic [1:0] TransIdle   = 2'b00;
   localparam logic [1:0] TransNonseq = 2'b10;
   localparam logic [1:0] TransSeq    = 2'b11;
   localparam logic [1:0] RespError   = 2'b01;
   localparam logic [2:0] BurstSingle = 3'b000;
   localparam logic [2:0] BurstIncr   = 3'b001;
   localparam logic [2:0] SizeWord    = 3'b010;

   typedef enum logic [1:0] {
      StIdle,
      StAddr,
      StLast,
      StErr1
   } state_e;

   state_e           state_q;
   logic [LEN_W-1:0] cnt_q;
   logic             dp_q;      // a data phase is in progress this cycle
   logic [31:0]      haddr_q;
   logic             hwrite_q;
   logic [1:0]       htrans_q;
   logic [2:0]       hburst_q;
   logic [31:0]      hwdata_q;
   logic [31:0]      rd_data_q;
   logic             rd_valid_q;
   logic             done_q;
   logic             err_q;

   logic [31:0]      haddr_inc;
   logic             unused_addr_lsb;

   assign haddr_inc       = haddr_q + 32'd4;
   assign unused_addr_lsb = ^cmd_addr[1:0];

   // Error response first cycle: slave stalls with ERROR while a data phase is pending.
   logic err_first;
   assign err_first = dp_q && !Hreadyout && (Hresp == RespError);

   // Sequencer: command accept, address/data pipeline, read capture and termination.
   always_ff @(posedge Hclk) begin
      if (!Hresetn) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         dp_q       <= 1'b0;
         haddr_q    <= '0;
         hwrite_q   <= 1'b0;
         htrans_q   <= TransIdle;
         hburst_q   <= BurstSingle;
         hwdata_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  state_q  <= StAddr;
                  htrans_q <= TransNonseq;
                  haddr_q  <= {cmd_addr[31:2], 2'b00};
                  hwrite_q <= cmd_write;
                  hburst_q <= (cmd_len == '0) ? BurstSingle : BurstIncr;
                  cnt_q    <= cmd_len;
                  dp_q     <= 1'b0;
               end
            end
            StAddr: begin
               if (err_first) begin
                  // Cancel the pending address; remaining beats are dropped.
                  state_q  <= StErr1;
                  htrans_q <= TransIdle;
               end else if (Hreadyout) begin
                  if (dp_q && !hwrite_q) begin
                     rd_data_q  <= Hrdata;
                     rd_valid_q <= 1'b1;
                  end
                  if (hwrite_q) begin
                     hwdata_q <= wr_data;
                  end
                  dp_q <= 1'b1;
                  if (cnt_q != '0) begin
                     cnt_q    <= cnt_q - LEN_W'(1);
                     haddr_q  <= haddr_inc;
                     // A burst may not cross a 1KB boundary, so restart it there.
                     htrans_q <= (haddr_inc[9:0] == 10'd0) ? TransNonseq : TransSeq;
                  end else begin
                     state_q  <= StLast;
                     htrans_q <= TransIdle;
                  end
               end
            end
            StLast: begin
               if (err_first) begin
                  state_q <= StErr1;
               end else if (Hreadyout) begin
                  if (!hwrite_q) begin
                     rd_data_q  <= Hrdata;
                     rd_valid_q <= 1'b1;
                  end
                  state_q <= StIdle;
                  dp_q    <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            StErr1: begin
               if (Hreadyout) begin
                  state_q <= StIdle;
                  dp_q    <= 1'b0;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Write data for the beat in address phase is taken whenever that phase is accepted.
   assign wr_req    = (state_q == StAddr) && hwrite_q && Hreadyout;
   assign cmd_ready = (state_q == StIdle);

   assign Haddr    = haddr_q;
   assign Hwrite   = hwrite_q;
   assign Htrans   = htrans_q;
   assign Hsize    = SizeWord;
   assign Hburst   = hburst_q;
   assign Hwdata   = hwdata_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_ahb_master_if.sv
// Directed bench for ahb_master_if: the bench plays both the command source and the
// AHB slave cycle by cycle, with hand-computed expectations for every checked cycle.
module tb_ahb_master_if;

   localparam int unsigned LEN_W = 4;
   localparam logic [1:0]  OKAY  = 2'b00;
   localparam logic [1:0]  ERROR = 2'b01;

   logic             Hclk;
   logic             Hresetn;
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_write;
   logic [31:0]      cmd_addr;
   logic [LEN_W-1:0] cmd_len;
   logic [31:0]      wr_data;
   logic             wr_req;
   logic             Hreadyout;
   logic [1:0]       Hresp;
   logic [31:0]      Hrdata;
   logic [31:0]      Haddr;
   logic             Hwrite;
   logic [1:0]       Htrans;
   logic [2:0]       Hsize;
   logic [2:0]       Hburst;
   logic [31:0]      Hwdata;
   logic [31:0]      rd_data;
   logic             rd_valid;
   logic             done;
   logic             err;

   int n_checks = 0;
   int n_errors = 0;
   int n_wrreq  = 0;
   int n_rdv    = 0;
   int n_done   = 0;
   int n_err    = 0;
   int b_wrreq, b_rdv, b_done, b_err;

   ahb_master_if #(
      .LEN_W(LEN_W)
   ) u_dut (
      .Hclk      (Hclk),
      .Hresetn   (Hresetn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wr_data   (wr_data),
      .wr_req    (wr_req),
      .Hreadyout (Hreadyout),
      .Hresp     (Hresp),
      .Hrdata    (Hrdata),
      .Haddr     (Haddr),
      .Hwrite    (Hwrite),
      .Htrans    (Htrans),
      .Hsize     (Hsize),
      .Hburst    (Hburst),
      .Hwdata    (Hwdata),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .done      (done),
      .err       (err)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   // Pulse counters, sampled mid-cycle once per clock.
   always @(negedge Hclk) begin
      #2;
      if (wr_req === 1'b1)   n_wrreq++;
      if (rd_valid === 1'b1) n_rdv++;
      if (done === 1'b1)     n_done++;
      if (err === 1'b1)      n_err++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle as the slave: drive the response, then let outputs settle.
   task automatic cyc(input logic rdy, input logic [1:0] resp, input logic [31:0] rdata);
      @(negedge Hclk);
      Hreadyout = rdy;
      Hresp     = resp;
      Hrdata    = rdata;
      #1;
   endtask

   task automatic bases();
      b_wrreq = n_wrreq;
      b_rdv   = n_rdv;
      b_done  = n_done;
      b_err   = n_err;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_htrans"},   32'(Htrans),    32'h0);
      check({tag, "_haddr"},    Haddr,          32'h0);
      check({tag, "_hwrite"},   32'(Hwrite),    32'h0);
      check({tag, "_hwdata"},   Hwdata,         32'h0);
      check({tag, "_hburst"},   32'(Hburst),    32'h0);
      check({tag, "_hsize"},    32'(Hsize),     32'h2);
      check({tag, "_rd_data"},  rd_data,        32'h0);
      check({tag, "_rd_valid"}, 32'(rd_valid),  32'h0);
      check({tag, "_wr_req"},   32'(wr_req),    32'h0);
      check({tag, "_done"},     32'(done),      32'h0);
      check({tag, "_err"},      32'(err),       32'h0);
      check({tag, "_cmd_ready"},32'(cmd_ready), 32'h1);
   endtask

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [LEN_W-1:0] len);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_len   = len;
   endtask

   initial begin
      Hresetn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      wr_data   = '0;
      Hreadyout = 1'b1;
      Hresp     = OKAY;
      Hrdata    = '0;

      // Reset state
      cyc(1'b1, OKAY, 32'h0);
      check_reset_values("rst");
      cyc(1'b1, OKAY, 32'h0);
      Hresetn = 1'b1;

      // Single write; low address bits must be forced to zero
      cyc(1'b1, OKAY, 32'h0);
      issue(1'b1, 32'h8000_0013, 4'd0);
      wr_data = 32'hDEAD_BEEF;
      bases();
      cyc(1'b1, OKAY, 32'h0);
      cmd_valid = 1'b0;
      check("w1_htrans", 32'(Htrans), 32'h2);
      check("w1_haddr", Haddr, 32'h8000_0010);
      check("w1_hburst", 32'(Hburst), 32'h0);
      check("w1_hwrite", 32'(Hwrite), 32'h1);
      check("w1_wr_req", 32'(wr_req), 32'h1);
      check("w1_cmd_ready", 32'(cmd_ready), 32'h0);
      cyc(1'b1, OKAY, 32'h0);
      check("w1_htrans_idle", 32'(Htrans), 32'h0);
      check("w1_hwdata", Hwdata, 32'hDEAD_BEEF);
      check("w1_done_early", 32'(done), 32'h0);
      cyc(1'b1, OKAY, 32'h0);
      check("w1_done", 32'(done), 32'h1);
      check("w1_err", 32'(err), 32'h0);
      check("w1_cmd_ready_back", 32'(cmd_ready), 32'h1);
      cyc(1'b1, OKAY, 32'h0);
      check("w1_wr_req_cnt", 32'(n_wrreq - b_wrreq), 32'd1);
      check("w1_done_cnt", 32'(n_done - b_done), 32'd1);

      // 4-beat read, two wait states on the second beat's data phase
      issue(1'b0, 32'h8400_0000, 4'd3);
      bases();
      cyc(1'b1, OKAY, 32'h0);
      cmd_valid = 1'b0;
      check("r4_b0_htrans", 32'(Htrans), 32'h2);
      check("r4_b0_haddr", Haddr, 32'h8400_0000);
      check("r4_hburst", 32'(Hburst), 32'h1);
      cyc(1'b1, OKAY, 32'h1111_0000);
      check("r4_b1_htrans", 32'(Htrans), 32'h3);
      check("r4_b1_haddr", Haddr, 32'h8400_0004);
      cyc(1'b0, OKAY, 32'h0);
      check("r4_b2_haddr", Haddr, 32'h8400_0008);
      check("r4_b2_htrans", 32'(Htrans), 32'h3);
      check("r4_rv0", 32'(rd_valid), 32'h1);
      check("r4_rd0", rd_data, 32'h1111_0000);
      cyc(1'b0, OKAY, 32'h0);
      check("r4_wait_haddr", Haddr, 32'h8400_0008);
      check("r4_wait_htrans", 32'(Htrans), 32'h3);
      check("r4_wait_rv", 32'(rd_valid), 32'h0);
      cyc(1'b1, OKAY, 32'h1111_0001);
      check("r4_wait2_haddr", Haddr, 32'h8400_0008);
      cyc(1'b1, OKAY, 32'h1111_0002);
      check("r4_b3_haddr", Haddr, 32'h8400_000C);
      check("r4_b3_htrans", 32'(Htrans), 32'h3);
      check("r4_rd1", rd_data, 32'h1111_0001);
      cyc(1'b1, OKAY, 32'h1111_0003);
      check("r4_last_htrans", 32'(Htrans), 32'h0);
      check("r4_rd2", rd_data, 32'h1111_0002);
      cyc(1'b1, OKAY, 32'h0);
      check("r4_done", 32'(done), 32'h1);
      check("r4_rd3", rd_data, 32'h1111_0003);
      check("r4_rv3", 32'(rd_valid), 32'h1);
      cyc(1'b1, OKAY, 32'h0);
      check("r4_rv_cnt", 32'(n_rdv - b_rdv), 32'd4);
      check("r4_done_cnt", 32'(n_done - b_done), 32'd1);
      check("r4_err_cnt", 32'(n_err - b_err), 32'd0);

      // 3-beat write across a 1KB boundary
      issue(1'b1, 32'h8800_03F8, 4'd2);
      wr_data = 32'hA0A0_0000;
      bases();
      cyc(1'b1, OKAY, 32'h0);
      cmd_valid = 1'b0;
      check("w3_b0_htrans", 32'(Htrans), 32'h2);
      check("w3_b0_haddr", Haddr, 32'h8800_03F8);
      check("w3_b0_wr_req", 32'(wr_req), 32'h1);
      cyc(1'b1, OKAY, 32'h0);
      wr_data = 32'hA0A0_0001;
      check("w3_b1_htrans", 32'(Htrans), 32'h3);
      check("w3_b1_haddr", Haddr, 32'h8800_03FC);
      check("w3_hwdata0", Hwdata, 32'hA0A0_0000);
      cyc(1'b1, OKAY, 32'h0);
      wr_data = 32'hA0A0_0002;
      check("w3_b2_htrans", 32'(Htrans), 32'h2);
      check("w3_b2_haddr", Haddr, 32'h8800_0400);
      check("w3_hwdata1", Hwdata, 32'hA0A0_0001);
      check("w3_hburst", 32'(Hburst), 32'h1);
      cyc(1'b1, OKAY, 32'h0);
      check("w3_last_htrans", 32'(Htrans), 32'h0);
      check("w3_hwdata2", Hwdata, 32'hA0A0_0002);
      check("w3_last_wr_req", 32'(wr_req), 32'h0);
      cyc(1'b1, OKAY, 32'h0);
      check("w3_done", 32'(done), 32'h1);
      cyc(1'b1, OKAY, 32'h0);
      check("w3_wr_req_cnt", 32'(n_wrreq - b_wrreq), 32'd3);

      // 4-beat read terminated by ERROR on the second beat
      issue(1'b0, 32'h8C00_0100, 4'd3);
      bases();
      cyc(1'b1, OKAY, 32'h0);
      cmd_valid = 1'b0;
      check("er_b0_htrans", 32'(Htrans), 32'h2);
      cyc(1'b1, OKAY, 32'hE0E0_0000);
      check("er_b1_haddr", Haddr, 32'h8C00_0104);
      cyc(1'b0, ERROR, 32'h0);
      check("er_rv0", 32'(rd_valid), 32'h1);
      check("er_rd0", rd_data, 32'hE0E0_0000);
      check("er_b2_htrans", 32'(Htrans), 32'h3);
      cyc(1'b1, ERROR, 32'hBAD0_BAD0);
      check("er_htrans_cancel", 32'(Htrans), 32'h0);
      check("er_cmd_ready_busy", 32'(cmd_ready), 32'h0);
      check("er_done_early", 32'(done), 32'h0);
      cyc(1'b1, OKAY, 32'h0);
      check("er_done", 32'(done), 32'h1);
      check("er_err", 32'(err), 32'h1);
      check("er_cmd_ready", 32'(cmd_ready), 32'h1);
      check("er_no_rv", 32'(rd_valid), 32'h0);
      cyc(1'b1, OKAY, 32'h0);
      check("er_done_pulse", 32'(done), 32'h0);
      check("er_err_pulse", 32'(err), 32'h0);
      check("er_rv_cnt", 32'(n_rdv - b_rdv), 32'd1);
      check("er_err_cnt", 32'(n_err - b_err), 32'd1);

      // Back-to-back commands with cmd_valid held
      issue(1'b0, 32'h9000_0100, 4'd0);
      bases();
      cyc(1'b1, OKAY, 32'h0);
      check("bb_a_htrans", 32'(Htrans), 32'h2);
      check("bb_a_haddr", Haddr, 32'h9000_0100);
      cmd_addr  = 32'h9000_0200;
      cmd_write = 1'b1;
      wr_data   = 32'h5555_AAAA;
      cyc(1'b1, OKAY, 32'h7777_0000);
      check("bb_a_last_htrans", 32'(Htrans), 32'h0);
      check("bb_a_cmd_ready", 32'(cmd_ready), 32'h0);
      cyc(1'b1, OKAY, 32'h0);
      check("bb_a_done", 32'(done), 32'h1);
      check("bb_a_rd", rd_data, 32'h7777_0000);
      check("bb_done_htrans", 32'(Htrans), 32'h0);
      check("bb_done_ready", 32'(cmd_ready), 32'h1);
      cyc(1'b1, OKAY, 32'h0);
      cmd_valid = 1'b0;
      check("bb_b_htrans", 32'(Htrans), 32'h2);
      check("bb_b_haddr", Haddr, 32'h9000_0200);
      check("bb_b_hwrite", 32'(Hwrite), 32'h1);
      cyc(1'b1, OKAY, 32'h0);
      check("bb_b_hwdata", Hwdata, 32'h5555_AAAA);
      cyc(1'b1, OKAY, 32'h0);
      check("bb_b_done", 32'(done), 32'h1);
      cyc(1'b1, OKAY, 32'h0);
      check("bb_done_cnt", 32'(n_done - b_done), 32'd2);

      // Reset in the middle of a burst, then a fresh command
      issue(1'b1, 32'h8000_0040, 4'd3);
      wr_data = 32'hC0C0_0000;
      bases();
      cyc(1'b1, OKAY, 32'h0);
      cmd_valid = 1'b0;
      check("rs_b0_htrans", 32'(Htrans), 32'h2);
      cyc(1'b1, OKAY, 32'h0);
      check("rs_b1_htrans", 32'(Htrans), 32'h3);
      Hresetn = 1'b0;
      cyc(1'b1, OKAY, 32'h0);
      check_reset_values("rs");
      Hresetn = 1'b1;
      cyc(1'b1, OKAY, 32'h0);
      check("rs_idle_htrans", 32'(Htrans), 32'h0);
      issue(1'b1, 32'h8000_0080, 4'd0);
      wr_data = 32'h1234_5678;
      cyc(1'b1, OKAY, 32'h0);
      cmd_valid = 1'b0;
      check("rs_new_htrans", 32'(Htrans), 32'h2);
      check("rs_new_haddr", Haddr, 32'h8000_0080);
      cyc(1'b1, OKAY, 32'h0);
      check("rs_new_hwdata", Hwdata, 32'h1234_5678);
      cyc(1'b1, OKAY, 32'h0);
      check("rs_new_done", 32'(done), 32'h1);
      cyc(1'b1, OKAY, 32'h0);
      check("rs_done_cnt", 32'(n_done - b_done), 32'd1);
      check("rs_err_cnt", 32'(n_err - b_err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
